// File: rtl/sc_dmem_io.sv
// Data-side memory and memory-mapped I/O for the single-cycle CPU.
// Provides word RAM, LEDs, synchronized switches, a timer with compare, and a byte TX FIFO.
module sc_dmem_io #(
    parameter int DEPTH_WORDS = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        we,
    output logic [31:0] dataout,
    input  logic [9:0]  sw_in,
    output logic [9:0]  led_out,
    output logic        irq,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] OCC_FULL = (PW+1)'(FIFO_DEPTH);

    // IO register word offsets (addr[7:2])
    localparam logic [5:0] OFS_SW     = 6'h00;
    localparam logic [5:0] OFS_LED    = 6'h01;
    localparam logic [5:0] OFS_COUNT  = 6'h02;
    localparam logic [5:0] OFS_CMP    = 6'h03;
    localparam logic [5:0] OFS_STATUS = 6'h04;
    localparam logic [5:0] OFS_TX     = 6'h05;

    typedef struct packed {
        logic led;
        logic count;
        logic cmp;
        logic status;
        logic tx;
    } io_wr_t;

    logic          ram_sel;
    logic          io_sel;
    logic [AW-1:0] ram_idx;
    logic [5:0]    io_ofs;
    io_wr_t        io_wr;
    logic          unused_bits;

    assign ram_sel     = (addr[31:AW+2] == '0);
    assign io_sel      = (addr[31:8] == 24'hFFFFFF);
    assign ram_idx     = addr[AW+1:2];
    assign io_ofs      = addr[7:2];
    assign unused_bits = ^addr[1:0];

    always_comb begin
        io_wr        = '0;
        if (we && io_sel) begin
            io_wr.led    = (io_ofs == OFS_LED);
            io_wr.count  = (io_ofs == OFS_COUNT);
            io_wr.cmp    = (io_ofs == OFS_CMP);
            io_wr.status = (io_ofs == OFS_STATUS);
            io_wr.tx     = (io_ofs == OFS_TX);
        end
    end

    // RAM: combinational read, contents untouched by reset
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we && ram_sel)
            mem[ram_idx] <= datain;
    end

    // Registers
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;
    logic [9:0]  led_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic        ovf;

    // FIFO state
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   occ;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;

    assign full    = (occ == OCC_FULL);
    assign empty   = (occ == '0);
    assign pop     = !empty && tx_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign push_ok = io_wr.tx && (!full || pop);

    always_ff @(posedge clock) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= datain[7:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
            led_q   <= '0;
            count   <= '0;
            compare <= 32'hFFFF_FFFF;
            match   <= 1'b0;
            ovf     <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;

            if (io_wr.led)
                led_q <= datain[9:0];

            count <= io_wr.count ? 32'd0 : count + 32'd1;

            if (io_wr.cmp)
                compare <= datain;

            // Match is sampled on the pre-increment count; set beats clear
            if (count == compare)
                match <= 1'b1;
            else if (io_wr.status && datain[0])
                match <= 1'b0;

            if (io_wr.tx && full && !pop)
                ovf <= 1'b1;
            else if (io_wr.status && datain[3])
                ovf <= 1'b0;

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign led_out  = led_q;
    assign irq      = match;
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    // Load path
    always_comb begin
        dataout = '0;
        if (ram_sel) begin
            dataout = mem[ram_idx];
        end else if (io_sel) begin
            case (io_ofs)
                OFS_SW:     dataout = {22'b0, sw_sync};
                OFS_LED:    dataout = {22'b0, led_q};
                OFS_COUNT:  dataout = count;
                OFS_CMP:    dataout = compare;
                OFS_STATUS: dataout = {28'b0, ovf, empty, full, match};
                default:    dataout = '0;
            endcase
        end
    end

endmodule
